fibonacci_gen: RTL and testbench

FIBONACCI_GEN -- requirements
Module: fibonacci_gen

---
 rtl/fibonacci_pkg.sv | 29 ++
 rtl/fibonacci_gen_if.sv | 40 ++++
 rtl/fibonacci_gen.sv | 111 +++++++++++
 tb/tb_fibonacci_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fibonacci_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fibonacci_pkg
// Purpose : Shared types and constants for the Fibonacci/Lucas generator.
//           Holds the controller state enum, the sequence-select enum and
//           the seed values for both sequences.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package fibonacci_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    MODE_FIB   = 1'b0,
    MODE_LUCAS = 1'b1
  } mode_t;

  localparam int FIB_SEED0 = 0;
  localparam int FIB_SEED1 = 1;
  localparam int LUC_SEED0 = 2;
  localparam int LUC_SEED1 = 1;

endpackage
`default_nettype wire

// File: rtl/fibonacci_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : fibonacci_gen_if
// Purpose : Request/result bundle for fibonacci_gen.
// Ports   : din      - sequence index n (requester -> generator)
//           start    - request pulse     (requester -> generator)
//           mode     - sequence select   (requester -> generator)
//           dout     - term n            (generator -> requester)
//           done     - result valid level(generator -> requester)
//           busy     - calculating       (generator -> requester)
//           overflow - term n truncated  (generator -> requester)
// Revision: 1.0 - initial release
// ============================================================================
interface fibonacci_gen_if
  import fibonacci_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int IDX_WIDTH = 16
);

  logic [IDX_WIDTH-1:0] din;
  logic                 start;
  mode_t                mode;
  logic [WIDTH-1:0]     dout;
  logic                 done;
  logic                 busy;
  logic                 overflow;

  modport master (
    output din, start, mode,
    input  dout, done, busy, overflow
  );

  modport slave (
    input  din, start, mode,
    output dout, done, busy, overflow
  );

endinterface
`default_nettype wire

// File: rtl/fibonacci_gen.sv
`default_nettype none
// ============================================================================
// Module  : fibonacci_gen
// Purpose : Iterative generator for term n of the Fibonacci (0,1) or Lucas
//           (2,1) sequence, modulo 2^WIDTH, with a truncation flag.
//           One adder; one term advanced per cycle.
// Ports   : clk   - clock, rising edge
//           reset - synchronous active-high reset
//           bus   - fibonacci_gen_if.slave (din/start/mode in,
//                   dout/done/busy/overflow out)
// Revision: 1.0 - initial release
// ============================================================================
module fibonacci_gen
  import fibonacci_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int IDX_WIDTH = 16
) (
  input  wire logic      clk,
  input  wire logic      reset,
  fibonacci_gen_if.slave bus
);

  state_t               state;
  state_t               state_next;
  logic                 accept;

  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 a_tag;
  logic                 b_tag;
  logic [IDX_WIDTH-1:0] cnt;
  logic [WIDTH-1:0]     result;
  logic                 done_flag;
  logic                 ovf_flag;
  logic [WIDTH:0]       sum;

  // Extra MSB captures the carry out of the single adder.
  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      a_tag     <= 1'b0;
      b_tag     <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      done_flag <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (bus.mode == MODE_LUCAS) begin
          a <= WIDTH'(LUC_SEED0);
          b <= WIDTH'(LUC_SEED1);
        end else begin
          a <= WIDTH'(FIB_SEED0);
          b <= WIDTH'(FIB_SEED1);
        end
        cnt       <= bus.din;
        a_tag     <= 1'b0;
        b_tag     <= 1'b0;
        done_flag <= 1'b0;
        ovf_flag  <= 1'b0;
      end else if (state == CALC) begin
        if (cnt != '0) begin
          a     <= b;
          b     <= sum[WIDTH-1:0];
          // Once any term has wrapped, every later term is also too large,
          // so the tag is sticky as it shifts down the pair.
          a_tag <= b_tag;
          b_tag <= a_tag | b_tag | sum[WIDTH];
          cnt   <= cnt - IDX_WIDTH'(1);
        end else begin
          // Only term n (held in a) is reported; b's tag belongs to n+1.
          result    <= a;
          ovf_flag  <= a_tag;
          done_flag <= 1'b1;
        end
      end
    end
  end

  assign bus.dout     = result;
  assign bus.done     = done_flag;
  assign bus.overflow = ovf_flag;
  assign bus.busy     = (state == CALC);

endmodule
`default_nettype wire

// File: tb/tb_fibonacci_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_fibonacci_gen
// Purpose : Self-checking bench for fibonacci_gen: directed scenarios plus
//           randomized requests checked against an arithmetic reference.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fibonacci_gen;
  import fibonacci_pkg::*;

  localparam int WIDTH     = 16;
  localparam int IDX_WIDTH = 16;
  localparam int TIMEOUT   = 300;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  fibonacci_gen_if #(.WIDTH(WIDTH), .IDX_WIDTH(IDX_WIDTH)) bus ();

  fibonacci_gen #(.WIDTH(WIDTH), .IDX_WIDTH(IDX_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: true term n computed with wide arithmetic; truncation and
  // overflow are derived from the true value.
  function automatic void ref_term(input mode_t m, input int n,
                                   output logic [WIDTH-1:0] val, output logic ovf);
    longint unsigned x, y, t;
    x = (m == MODE_LUCAS) ? 64'd2 : 64'd0;
    y = 64'd1;
    for (int i = 0; i < n; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    val = x[WIDTH-1:0];
    ovf = (x >= (64'd1 << WIDTH));
  endfunction

  task automatic issue_start(input int n, input mode_t m);
    @(negedge clk);
    bus.din   = IDX_WIDTH'(n);
    bus.mode  = m;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.done && cycles < TIMEOUT) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic run_op(input int n, input mode_t m, output int cycles);
    issue_start(n, m);
    wait_done(cycles);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b1;   // reset must win over a simultaneous start
    bus.din   = IDX_WIDTH'(3);
    bus.mode  = MODE_FIB;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (bus.dout !== '0) $display("FAIL reset_dout: got %0d want 0", bus.dout); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", bus.overflow); else pass_cnt++;
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fib_basic();
    int ns  [4] = '{5, 2, 1, 6};
    int exp [4] = '{5, 1, 1, 8};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      run_op(ns[i], MODE_FIB, cyc);
      total_cnt++; if (cyc !== ns[i] + 1) $display("FAIL fib_latency n=%0d: got %0d want %0d", ns[i], cyc, ns[i] + 1); else pass_cnt++;
      total_cnt++; if (bus.dout !== WIDTH'(exp[i])) $display("FAIL fib_dout n=%0d: got %0d want %0d", ns[i], bus.dout, exp[i]); else pass_cnt++;
      total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL fib_overflow n=%0d: got %b want 0", ns[i], bus.overflow); else pass_cnt++;
    end
    // Result must hold in DONE while no start arrives.
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (bus.done !== 1'b1 || bus.dout !== WIDTH'(8)) $display("FAIL done_hold: got done=%b dout=%0d want done=1 dout=8", bus.done, bus.dout); else pass_cnt++;
  endtask

  task automatic test_zero_and_lucas();
    int    ns  [3] = '{0, 0, 5};
    mode_t ms  [3] = '{MODE_FIB, MODE_LUCAS, MODE_LUCAS};
    int    exp [3] = '{0, 2, 11};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      run_op(ns[i], ms[i], cyc);
      total_cnt++; if (cyc !== ns[i] + 1) $display("FAIL seq_latency case=%0d: got %0d want %0d", i, cyc, ns[i] + 1); else pass_cnt++;
      total_cnt++; if (bus.dout !== WIDTH'(exp[i])) $display("FAIL seq_dout case=%0d: got %0d want %0d", i, bus.dout, exp[i]); else pass_cnt++;
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    int busy_cnt;
    issue_start(10, MODE_FIB);
    busy_cnt = bus.busy ? 1 : 0;
    cyc = 0;
    while (!bus.done && cyc < TIMEOUT) begin
      if (cyc == 3) begin
        bus.start = 1'b1;
        bus.din   = IDX_WIDTH'(3);
        bus.mode  = MODE_LUCAS;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (bus.busy) busy_cnt++;
    end
    bus.start = 1'b0;
    total_cnt++; if (bus.dout !== WIDTH'(55)) $display("FAIL ignore_dout: got %0d want 55", bus.dout); else pass_cnt++;
    total_cnt++; if (cyc !== 11) $display("FAIL ignore_latency: got %0d want 11", cyc); else pass_cnt++;
    total_cnt++; if (busy_cnt !== 11) $display("FAIL ignore_busy_cycles: got %0d want 11", busy_cnt); else pass_cnt++;
  endtask

  task automatic test_overflow();
    int cyc;
    run_op(24, MODE_FIB, cyc);
    total_cnt++; if (bus.dout !== WIDTH'(46368)) $display("FAIL ovf24_dout: got %0d want 46368", bus.dout); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL ovf24_flag: got %b want 0", bus.overflow); else pass_cnt++;
    run_op(25, MODE_FIB, cyc);
    total_cnt++; if (bus.dout !== WIDTH'(9489)) $display("FAIL ovf25_dout: got %0d want 9489", bus.dout); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL ovf25_flag: got %b want 1", bus.overflow); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (bus.overflow !== 1'b1 || bus.done !== 1'b1) $display("FAIL ovf_hold: got ovf=%b done=%b want 1 1", bus.overflow, bus.done); else pass_cnt++;
  endtask

  task automatic test_reset_midcalc();
    int cyc;
    issue_start(20, MODE_FIB);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++; if (bus.dout !== '0) $display("FAIL midrst_dout: got %0d want 0", bus.dout); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL midrst_done: got %b want 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL midrst_overflow: got %b want 0", bus.overflow); else pass_cnt++;
    reset = 1'b0;
    run_op(6, MODE_FIB, cyc);
    total_cnt++; if (bus.dout !== WIDTH'(8) || cyc !== 7) $display("FAIL after_rst: got dout=%0d cyc=%0d want 8 7", bus.dout, cyc); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    issue_start(7, MODE_FIB);
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL b2b_done_drop: got %b want 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", bus.busy); else pass_cnt++;
    wait_done(cyc);
    total_cnt++; if (cyc !== 8) $display("FAIL b2b_latency: got %0d want 8", cyc); else pass_cnt++;
    total_cnt++; if (bus.dout !== WIDTH'(13)) $display("FAIL b2b_dout: got %0d want 13", bus.dout); else pass_cnt++;
  endtask

  task automatic test_random();
    int               n;
    int               cyc;
    mode_t            m;
    logic [WIDTH-1:0] ev;
    logic             eo;
    for (int i = 0; i < 16; i++) begin
      n = int'($urandom_range(0, 40));
      m = mode_t'($urandom_range(0, 1));
      ref_term(m, n, ev, eo);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_op(n, m, cyc);
      total_cnt++; if (bus.dout !== ev || bus.overflow !== eo || cyc !== n + 1)
        $display("FAIL rand n=%0d mode=%0d: got dout=%0d ovf=%b cyc=%0d want dout=%0d ovf=%b cyc=%0d",
                 n, m, bus.dout, bus.overflow, cyc, ev, eo, n + 1);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_fib_basic();
    test_zero_and_lucas();
    test_ignore_start();
    test_overflow();
    test_reset_midcalc();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
